// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: assembles 16-bit words from a byte-wide program
// memory (high byte first) and presents them to the decoder with valid/ready.
module instruction_fetch #(
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_byte_sel,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH_HI = 2'd1;
    localparam logic [1:0] FETCH_LO = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [15:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next-state logic; a jump overrides every state and discards same-cycle rvalid/ready.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        hi_byte_d  = hi_byte_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        if (jump_en) begin
            fetch_pc_d = jump_addr;
            hi_byte_d  = 8'h00;
            valid_d    = 1'b0;
            state_d    = FETCH_HI;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH_HI;
                end
                FETCH_HI: begin
                    if (mem_rvalid) begin
                        hi_byte_d = mem_rdata;
                        state_d   = FETCH_LO;
                    end else begin
                        state_d = FETCH_HI;
                    end
                end
                FETCH_LO: begin
                    if (mem_rvalid) begin
                        instr_d    = {hi_byte_q, mem_rdata};
                        pc_d       = fetch_pc_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_ONE;
                        state_d    = HOLD;
                    end else begin
                        state_d = FETCH_LO;
                    end
                end
                HOLD: begin
                    if (valid_q && instr_ready) begin
                        valid_d = 1'b0;
                        state_d = FETCH_HI;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC_W;
            hi_byte_q  <= 8'h00;
            instr_q    <= 16'h0000;
            valid_q    <= 1'b0;
            pc_q       <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            hi_byte_q  <= hi_byte_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
        end
    end

    // Memory interface decodes from registered state only.
    always_comb begin
        mem_req      = 1'b0;
        mem_byte_sel = 1'b0;
        case (state_q)
            FETCH_HI: begin
                mem_req      = 1'b1;
                mem_byte_sel = 1'b0;
            end
            FETCH_LO: begin
                mem_req      = 1'b1;
                mem_byte_sel = 1'b1;
            end
            default: begin
                mem_req      = 1'b0;
                mem_byte_sel = 1'b0;
            end
        endcase
    end

    assign mem_addr    = fetch_pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule
